// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP link bring-up controller.
package sfp_pkg;

    localparam int unsigned CNT_W_DEF           = 27;
    localparam int unsigned DEBOUNCE_CYC_DEF    = 1_000_000;
    localparam int unsigned INIT_CYC_DEF        = 30_000_000;
    localparam int unsigned LOS_TIMEOUT_CYC_DEF = 10_000_000;
    localparam int unsigned RETRY_WAIT_CYC_DEF  = 50_000_000;
    localparam int unsigned MAX_RETRIES_DEF     = 3;

    typedef enum logic [2:0] {
        ST_ABSENT  = 3'd0,
        ST_INIT    = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_UP      = 3'd3,
        ST_RETRY   = 3'd4,
        ST_LOCKOUT = 3'd5
    } sfp_state_e;

    // Tone half-period terminal counts at 100 MHz:
    // 1 MHz, 250 kHz, 100 kHz, 50 kHz, 35 kHz, 25 kHz, 10 kHz, ~0.5 Hz.
    function automatic int unsigned tone_lookup(input logic [2:0] sel);
        case (sel)
            3'd0:    tone_lookup = 49;
            3'd1:    tone_lookup = 199;
            3'd2:    tone_lookup = 499;
            3'd3:    tone_lookup = 999;
            3'd4:    tone_lookup = 1427;
            3'd5:    tone_lookup = 1999;
            3'd6:    tone_lookup = 4999;
            default: tone_lookup = 99_999_999;
        endcase
    endfunction

endpackage

// File: rtl/sfp_debounce.sv
// Two-flop synchronizer followed by a stable-count filter. The filtered
// level moves only after the synced input has disagreed with it for
// DEBOUNCE_CYC consecutive samples; any agreeing sample restarts the count.
module sfp_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter logic        RESET_VAL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer, filtered level and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            filt_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive disagreeing samples; accept on the last one.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/sfp_link_ctrl.sv
// Link bring-up controller for one SFP cage: debounces presence and LOS,
// sequences TX_DISABLE through insertion, init, enable and fault retry,
// and gates the tone generator that drives the TX pin.
module sfp_link_ctrl
    import sfp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
    parameter int unsigned INIT_CYC        = INIT_CYC_DEF,
    parameter int unsigned LOS_TIMEOUT_CYC = LOS_TIMEOUT_CYC_DEF,
    parameter int unsigned RETRY_WAIT_CYC  = RETRY_WAIT_CYC_DEF,
    parameter int unsigned MAX_RETRIES     = MAX_RETRIES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sfp_detect,
    input  logic             sfp_los,
    output logic             sfp_shutdown,
    input  logic             force_off,
    input  logic             clear_fault,
    input  logic [2:0]       tone_sel,
    output logic             tone_en,
    output logic [CNT_W-1:0] tone_half_period,
    output logic             link_up,
    output logic [2:0]       state,
    output logic [1:0]       retry_cnt
);

    logic detect_f, los_f, present;

    sfp_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b1)) u_det (
        .clk(clk), .rst(rst), .raw_i(sfp_detect), .filt_o(detect_f)
    );

    sfp_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(1'b1)) u_los (
        .clk(clk), .rst(rst), .raw_i(sfp_los), .filt_o(los_f)
    );

    assign present = ~detect_f;

    sfp_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic             frz_q, frz_d, frz_now;
    logic             timer_clr, timer_hold;
    logic             shut_q, shut_d, tone_en_q, tone_en_d, link_q, link_d;
    logic [CNT_W-1:0] tone_hp_q;

    // State, timer, retry count, freeze flag and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ABSENT;
            timer_q   <= '0;
            retry_q   <= '0;
            frz_q     <= 1'b0;
            shut_q    <= 1'b1;
            tone_en_q <= 1'b0;
            link_q    <= 1'b0;
            tone_hp_q <= CNT_W'(tone_lookup(3'd0));
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            frz_q     <= frz_d;
            shut_q    <= shut_d;
            tone_en_q <= tone_en_d;
            link_q    <= link_d;
            tone_hp_q <= CNT_W'(tone_lookup(tone_sel));
        end
    end

    // Next state with removal > force_off > normal sequencing; outputs are
    // derived from the next state so they land together with it.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        frz_d      = frz_q;
        timer_clr  = 1'b0;
        timer_hold = 1'b0;
        timer_inc  = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);
        retry_inc  = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
        frz_now    = force_off && (state_q inside {ST_INIT, ST_ENABLE, ST_UP, ST_RETRY});

        if (!present) begin
            state_d = ST_ABSENT;
            retry_d = '0;
            frz_d   = 1'b0;
        end else if (frz_now) begin
            frz_d      = 1'b1;
            timer_hold = 1'b1;
        end else if (frz_q) begin
            // Release of force_off always restarts from INIT, even if frozen in INIT.
            state_d   = ST_INIT;
            frz_d     = 1'b0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                ST_ABSENT: begin
                    state_d = ST_INIT;
                    retry_d = '0;
                end
                ST_INIT: begin
                    if (timer_q == CNT_W'(INIT_CYC - 1)) state_d = ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (!los_f) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else if (timer_q == CNT_W'(LOS_TIMEOUT_CYC - 1)) begin
                        retry_d = retry_inc;
                        state_d = (32'(retry_inc) >= MAX_RETRIES) ? ST_LOCKOUT : ST_RETRY;
                    end
                end
                ST_UP: begin
                    if (los_f) begin
                        retry_d = retry_inc;
                        state_d = (32'(retry_inc) >= MAX_RETRIES) ? ST_LOCKOUT : ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    if (timer_q == CNT_W'(RETRY_WAIT_CYC - 1)) state_d = ST_ENABLE;
                end
                ST_LOCKOUT: begin
                    if (clear_fault) begin
                        state_d = ST_INIT;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_ABSENT;
            endcase
        end

        if (timer_clr || (state_d != state_q)) timer_d = '0;
        else if (timer_hold)                   timer_d = timer_q;
        else                                   timer_d = timer_inc;

        shut_d    = force_off || !(state_d inside {ST_ENABLE, ST_UP});
        tone_en_d = !force_off && (state_d == ST_UP);
        link_d    = !force_off && (state_d == ST_UP);
    end

    assign sfp_shutdown     = shut_q;
    assign tone_en          = tone_en_q;
    assign link_up          = link_q;
    assign tone_half_period = tone_hp_q;
    assign state            = state_q;
    assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed self-checking bench for sfp_link_ctrl with short timing parameters.
module tb_sfp_link_ctrl;

    localparam int unsigned CNT_W = 27;

    logic             clk = 1'b0;
    logic             rst, sfp_detect, sfp_los, force_off, clear_fault;
    logic [2:0]       tone_sel;
    logic             sfp_shutdown, tone_en, link_up;
    logic [CNT_W-1:0] tone_half_period;
    logic [2:0]       state;
    logic [1:0]       retry_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  sel;
        int unsigned hp;
    } tone_vec_t;

    tone_vec_t vecs [8];

    sfp_link_ctrl #(
        .DEBOUNCE_CYC(4), .INIT_CYC(16), .LOS_TIMEOUT_CYC(32),
        .RETRY_WAIT_CYC(8), .MAX_RETRIES(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sfp_detect(sfp_detect), .sfp_los(sfp_los),
        .sfp_shutdown(sfp_shutdown), .force_off(force_off), .clear_fault(clear_fault),
        .tone_sel(tone_sel), .tone_en(tone_en), .tone_half_period(tone_half_period),
        .link_up(link_up), .state(state), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bounded wait for a state; an expired budget counts as a failure.
    task automatic wait_state(input string name, input logic [2:0] exp, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (state == exp) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: got state %0d expected %0d within %0d cycles", name, state, exp, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_shutdown"}, sfp_shutdown, 1);
        check({tag, "_tone_en"}, tone_en, 0);
        check({tag, "_link_up"}, link_up, 0);
        check({tag, "_retry"}, retry_cnt, 0);
        check({tag, "_tone_hp"}, tone_half_period, 49);
    endtask

    initial begin
        vecs[0] = '{3'd7, 99_999_999};
        vecs[1] = '{3'd0, 49};
        vecs[2] = '{3'd5, 1999};
        vecs[3] = '{3'd2, 499};
        vecs[4] = '{3'd6, 4999};
        vecs[5] = '{3'd1, 199};
        vecs[6] = '{3'd4, 1427};
        vecs[7] = '{3'd3, 999};

        rst = 1; sfp_detect = 1; sfp_los = 1; force_off = 0; clear_fault = 0; tone_sel = 3'd0;

        // 1: reset, insertion, init
        tick(3);
        check_reset_outputs("rst");
        rst = 0;
        tick(1);
        check("absent_hold", state, 0);
        sfp_detect = 0;
        // filter accepts after 2+4 edges, state register adds one more
        tick(6);
        check("ins_not_yet", state, 0);
        tick(1);
        check("ins_init", state, 1);
        check("init_shutdown", sfp_shutdown, 1);
        tick(15);
        check("init_hold", state, 1);
        tick(1);
        check("init_to_enable", state, 2);
        check("enable_shutdown", sfp_shutdown, 0);

        // 2: LOS clears -> UP, tone table
        sfp_los = 0;
        tick(6);
        check("enable_hold", state, 2);
        tick(1);
        check("up_state", state, 3);
        check("up_link", link_up, 1);
        check("up_tone_en", tone_en, 1);
        check("up_retry", retry_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            tone_sel = vecs[i].sel;
            tick(1);
            check($sformatf("tone_sel%0d", vecs[i].sel), tone_half_period, vecs[i].hp);
        end

        // 3: 3-cycle LOS glitch rejected, then real loss -> RETRY -> ENABLE
        sfp_los = 1;
        tick(3);
        sfp_los = 0;
        tick(10);
        check("glitch_stays_up", state, 3);
        sfp_los = 1;
        tick(6);
        check("loss_not_yet", state, 3);
        tick(1);
        check("loss_retry", state, 4);
        check("loss_retry_cnt", retry_cnt, 1);
        check("retry_shutdown", sfp_shutdown, 1);
        check("retry_tone_en", tone_en, 0);
        tick(7);
        check("retry_hold", state, 4);
        tick(1);
        check("retry_to_enable", state, 2);

        // 4: LOS held through enable windows -> LOCKOUT
        tick(31);
        check("timeout1_hold", state, 2);
        tick(1);
        check("timeout1_retry", state, 4);
        check("timeout1_cnt", retry_cnt, 2);
        tick(1);
        clear_fault = 1;
        tick(1);
        clear_fault = 0;
        check("clear_ignored", state, 4);
        check("clear_ignored_cnt", retry_cnt, 2);
        tick(5);
        check("retry2_hold", state, 4);
        tick(1);
        check("retry2_enable", state, 2);
        tick(31);
        check("timeout2_hold", state, 2);
        tick(1);
        check("lockout_state", state, 5);
        check("lockout_cnt", retry_cnt, 3);
        check("lockout_shutdown", sfp_shutdown, 1);
        tick(20);
        check("lockout_hold", state, 5);
        clear_fault = 1;
        tick(1);
        clear_fault = 0;
        check("clear_init", state, 1);
        check("clear_cnt", retry_cnt, 0);

        // 5: force_off in UP freezes, release restarts from INIT
        sfp_los = 0;
        wait_state("reach_up", 3'd3, 40);
        force_off = 1;
        tick(1);
        check("force_shutdown", sfp_shutdown, 1);
        check("force_tone_en", tone_en, 0);
        check("force_frozen", state, 3);
        tick(20);
        check("force_still_frozen", state, 3);
        force_off = 0;
        tick(1);
        check("release_init", state, 1);
        check("release_shutdown", sfp_shutdown, 1);
        tick(15);
        check("release_init_hold", state, 1);
        tick(1);
        check("release_enable", state, 2);
        wait_state("reach_up2", 3'd3, 10);

        // 6: removal in RETRY and in LOCKOUT, then reset mid-INIT
        sfp_los = 1;
        wait_state("reach_retry", 3'd4, 10);
        sfp_detect = 1;
        tick(6);
        check("rm_retry_not_yet", state, 4);
        tick(1);
        check("rm_retry_absent", state, 0);
        check("rm_retry_cnt", retry_cnt, 0);
        check("rm_retry_shutdown", sfp_shutdown, 1);
        sfp_detect = 0;
        wait_state("reach_lockout", 3'd5, 300);
        check("lockout2_cnt", retry_cnt, 3);
        sfp_detect = 1;
        tick(6);
        check("rm_lock_not_yet", state, 5);
        tick(1);
        check("rm_lock_absent", state, 0);
        check("rm_lock_cnt", retry_cnt, 0);
        sfp_detect = 0;
        tone_sel = 3'd5;
        wait_state("reach_init", 3'd1, 20);
        tick(3);
        rst = 1;
        tick(1);
        check_reset_outputs("midinit_rst");
        rst = 0;
        tick(1);
        check("post_rst_tone", tone_half_period, 1999);
        check("post_rst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
